// File: rtl/chiplet_types_pkg.sv
// Shared types for the chiplet link and switch datapath.
// Holds the flit format, the VC index type and the input-buffer FSM states.
package chiplet_types_pkg;

  localparam int unsigned FlitWidth     = 8;
  localparam int unsigned NumVcsDefault = 2;

  typedef logic [FlitWidth-1:0] flit_t;

  typedef logic [$clog2(NumVcsDefault)-1:0] vc_id_t;

  typedef enum logic {
    StIdle,
    StHold
  } ib_state_e;

endpackage

// File: rtl/vc_fifo.sv
// Single-VC circular flit FIFO with registered read/write pointers and occupancy count.
// The head is read straight from storage, so a new flit is visible only after its write edge.
module vc_fifo
  import chiplet_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  flit_t                      din,
  output flit_t                      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  flit_t            mem [DEPTH];
  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q] <= din;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-link input buffer: one FIFO per VC, round-robin head selection and a HOLD state
// that pins the presented VC until the switch accepts it.
module vc_input_buffer
  import chiplet_types_pkg::*;
#(
  parameter int unsigned NUM_VCS = NumVcsDefault,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  flit_t                      in_flit,
  input  logic                       in_valid,
  input  logic [$clog2(NUM_VCS)-1:0] in_vc,
  output logic [NUM_VCS-1:0]         credit_return,
  output flit_t                      out_flit,
  output logic                       out_valid,
  output logic [$clog2(NUM_VCS)-1:0] out_vc,
  input  logic                       out_ready,
  output logic [NUM_VCS-1:0]         buffer_available,
  output logic                       overflow_err
);

  localparam int unsigned VcW  = $clog2(NUM_VCS);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  flit_t              head [NUM_VCS];
  logic [CntW-1:0]    count [NUM_VCS];
  logic [NUM_VCS-1:0] full, empty, push, pop;

  ib_state_e          state_q, state_d;
  logic [VcW-1:0]     sel_q, sel_d;
  logic [VcW-1:0]     rr_q, rr_d;
  logic [NUM_VCS-1:0] credit_q;
  logic               overflow_q;

  logic               found;
  logic [VcW-1:0]     rr_sel;
  int unsigned        idx;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    vc_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (in_flit),
      .dout  (head[v]),
      .full  (full[v]),
      .empty (empty[v]),
      .count (count[v])
    );

    // Fullness comes from the pre-edge count, so a simultaneous pop never frees a slot.
    assign push[v]             = in_valid && (in_vc == VcW'(v)) && !full[v];
    assign buffer_available[v] = (count[v] != CntW'(DEPTH));
  end

  always_comb begin
    found  = 1'b0;
    rr_sel = '0;
    idx    = 0;
    for (int i = 0; i < NUM_VCS; i++) begin
      idx = (int'(rr_q) + i) % NUM_VCS;
      if (!found && !empty[idx]) begin
        found  = 1'b1;
        rr_sel = VcW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    out_valid = 1'b0;
    out_vc    = '0;
    pop       = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          out_valid = 1'b1;
          out_vc    = rr_sel;
          if (out_ready) begin
            pop[rr_sel] = 1'b1;
            rr_d        = VcW'((int'(rr_sel) + 1) % NUM_VCS);
          end else begin
            sel_d   = rr_sel;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        out_valid = 1'b1;
        out_vc    = sel_q;
        if (out_ready) begin
          pop[sel_q] = 1'b1;
          rr_d       = VcW'((int'(sel_q) + 1) % NUM_VCS);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_flit      = out_valid ? head[out_vc] : '0;
  assign credit_return = credit_q;
  assign overflow_err  = overflow_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      rr_q       <= '0;
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
      credit_q <= pop;
      if (in_valid && full[in_vc]) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule
